cmd_uart_wrapper: RTL

Robot-side command front end of the Knight's Tour design. It receives the two-byte commands sent by the remote over a 19200-baud 8N1 serial link and assembles them into one 16-bit command for the command processor. It also serialises the 8-bit response/acknowledge byte back to the remote. It sits between the top-level RX/TX pins and the command processor.

---
 rtl/cmd_uart_wrapper_pkg.sv | 31 +++
 rtl/uart_xcvr.sv | 134 +++++++++++++
 rtl/cmd_uart_wrapper.sv | 74 +++++++
 3 files changed

// File: rtl/cmd_uart_wrapper_pkg.sv
// Knight's Tour command definitions shared by the robot-side UART front end.
// Stop-bit checking is enabled when CMD_FRAME_CHK_EN is defined.
package cmd_uart_wrapper_pkg;

   localparam int CMD_HI_MSB = 15;
   localparam int CMD_HI_LSB = 8;
   localparam int CMD_LO_MSB = 7;
   localparam int CMD_LO_LSB = 0;

   localparam logic [7:0] RESP_ACK = 8'hA5;

`ifdef CMD_FRAME_CHK_EN
   localparam bit FRAME_CHK_EN = 1'b1;
`else
   localparam bit FRAME_CHK_EN = 1'b0;
`endif

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } wrap_state_t;

   function automatic logic [15:0] pack_cmd(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] c;
      c = '0;
      c[CMD_HI_MSB:CMD_HI_LSB] = hi;
      c[CMD_LO_MSB:CMD_LO_LSB] = lo;
      return c;
   endfunction

endpackage

// File: rtl/uart_xcvr.sv
// 8N1 receiver/transmitter pair with BAUD_DIV clocks per bit; RX and TX are
// independent. Bad stop bits are trapped only when CMD_FRAME_CHK_EN is defined.
//
// rx state | meaning
// ---------+------------------------------------------------
// RX_IDLE  | armed, waiting for a synchronised falling edge
// RX_BUSY  | sampling start, 8 data and stop at mid-bit
// RX_HOLD  | stop sample was 0, waiting for the line to go high
module uart_xcvr
   import cmd_uart_wrapper_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rx_byte,
   output logic       rx_rdy,
   output logic       frm_err,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] RX_HALF  = CNT_W'(BAUD_DIV / 2);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_BUSY = 2'd1,
      RX_HOLD = 2'd2
   } rx_state_t;

   rx_state_t        rx_state;
   logic             rx_ff1, rx_sync, rx_sync_d;
   logic [CNT_W-1:0] rx_cnt;
   logic [3:0]       rx_bit;
   logic [7:0]       rx_shift;

   logic             tx_busy;
   logic [CNT_W-1:0] tx_cnt;
   logic [3:0]       tx_bit;
   logic [8:0]       tx_shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_ff1    <= 1'b1;
         rx_sync   <= 1'b1;
         rx_sync_d <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_byte   <= '0;
         rx_rdy    <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         rx_ff1    <= rx;
         rx_sync   <= rx_ff1;
         rx_sync_d <= rx_sync;
         rx_rdy    <= 1'b0;
         frm_err   <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_sync_d && !rx_sync) begin
                  rx_cnt   <= RX_HALF;
                  rx_bit   <= '0;
                  rx_state <= RX_BUSY;
               end
            end
            RX_BUSY: begin
               if (rx_cnt == '0) begin
                  rx_cnt <= BIT_LAST;
                  rx_bit <= rx_bit + 4'd1;
                  if (rx_bit == 4'd9) begin
                     frm_err <= ~rx_sync;
                     if (FRAME_CHK_EN && !rx_sync) begin
                        rx_state <= RX_HOLD;
                     end else begin
                        rx_byte  <= rx_shift;
                        rx_rdy   <= 1'b1;
                        rx_state <= RX_IDLE;
                     end
                  end else if (rx_bit != 4'd0) begin
                     rx_shift <= {rx_sync, rx_shift[7:1]};
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_HOLD: begin
               if (rx_sync) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Idle shift register is all ones so tx can come straight off bit 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_shift <= '1;
         tx_busy  <= 1'b0;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_done  <= 1'b0;
      end else if (!tx_busy) begin
         if (trmt) begin
            tx_shift <= {tx_data, 1'b0};
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            tx_busy  <= 1'b1;
            tx_done  <= 1'b0;
         end
      end else if (tx_cnt == '0) begin
         if (tx_bit == 4'd9) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_shift <= '1;
         end else begin
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bit   <= tx_bit + 4'd1;
            tx_cnt   <= BIT_LAST;
         end
      end else begin
         tx_cnt <= tx_cnt - 1'b1;
      end
   end

   assign tx = tx_shift[0];

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Robot-side command front end: pairs received bytes into 16-bit commands and
// sends the response byte. CMD_FRAME_CHK_EN enables stop-bit checking.
//
// state   | meaning
// --------+--------------------------------------------
// WAIT_HI | next received byte is the command high byte
// WAIT_LO | high byte latched, next byte completes cmd
module cmd_uart_wrapper
   import cmd_uart_wrapper_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   wrap_state_t state;
   logic [7:0]  hi_byte;
   logic [7:0]  rx_byte;
   logic        rx_rdy;
   logic        frm_err;

   uart_xcvr #(
      .BAUD_DIV (BAUD_DIV)
   ) u_xcvr (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (RX),
      .tx      (TX),
      .rx_byte (rx_byte),
      .rx_rdy  (rx_rdy),
      .frm_err (frm_err),
      .trmt    (trmt),
      .tx_data (resp),
      .tx_done (tx_done)
   );

   // The low-byte set is written after the clear so it wins on a collision.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= WAIT_HI;
         hi_byte <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
      end else begin
         if (clr_cmd_rdy) cmd_rdy <= 1'b0;
         if (FRAME_CHK_EN && frm_err) state <= WAIT_HI;
         if (rx_rdy) begin
            case (state)
               WAIT_HI: begin
                  hi_byte <= rx_byte;
                  cmd_rdy <= 1'b0;
                  state   <= WAIT_LO;
               end
               WAIT_LO: begin
                  cmd     <= pack_cmd(hi_byte, rx_byte);
                  cmd_rdy <= 1'b1;
                  state   <= WAIT_HI;
               end
               default: state <= WAIT_HI;
            endcase
         end
      end
   end

endmodule
